// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of a single-port SDRAM controller.
// One access is in flight at a time: IDLE grants, ISSUE holds mem_start until
// the controller reports completion, DRAIN waits for the controller to go quiet
// and captures read data, ACK pulses the granted master's ack for one cycle.
module sdram_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0  // 0: round-robin, 1: master 0 wins ties
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic [23:0] m0_addr,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic [31:0] m0_q,

  input  logic        m1_req,
  input  logic [23:0] m1_addr,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic [31:0] m1_q,

  output logic        mem_start,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_d,
  output logic        mem_we,
  input  logic        mem_busy,
  input  logic        mem_q_ready,
  input  logic [31:0] mem_q,
  input  logic        mem_init_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  // Last (and, outside IDLE, current) grant: 0 = master 0, 1 = master 1.
  logic        last_gnt_q, last_gnt_d;
  logic        mem_start_q, mem_start_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_d_q, mem_d_d;
  logic        mem_we_q, mem_we_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  // Decoded one-cycle events from the FSM.
  logic        grant;
  logic        capture;

  // Next-state logic and grant decision.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    grant      = 1'b0;
    capture    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (mem_init_done && (m0_req || m1_req)) begin
          grant   = 1'b1;
          state_d = S_ISSUE;
          if (m0_req && m1_req) begin
            // Tie: fixed mode always favours master 0, round-robin flips.
            last_gnt_d = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_gnt_q;
          end else begin
            last_gnt_d = m1_req;
          end
        end
      end

      S_ISSUE: begin
        // A refresh shows as busy without q_ready; only q_ready ends ISSUE.
        if (mem_q_ready) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (!mem_busy && !mem_q_ready) begin
          state_d = S_ACK;
          capture = 1'b1;
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request latch, read-data capture and registered handshake outputs.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    mem_we_d   = mem_we_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    if (grant) begin
      if (last_gnt_d) begin
        mem_addr_d = m1_addr;
        mem_d_d    = m1_d;
        mem_we_d   = m1_we;
      end else begin
        mem_addr_d = m0_addr;
        mem_d_d    = m0_d;
        mem_we_d   = m0_we;
      end
    end

    // Writes leave the owning master's read register untouched.
    if (capture && !mem_we_q) begin
      if (last_gnt_q) begin
        m1_rdata_d = mem_q;
      end else begin
        m0_rdata_d = mem_q;
      end
    end

    // Decoded from the next state so the outputs are flops aligned to it.
    mem_start_d = (state_d == S_ISSUE);
    m0_ack_d    = (state_d == S_ACK) && !last_gnt_d;
    m1_ack_d    = (state_d == S_ACK) &&  last_gnt_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      last_gnt_q  <= 1'b1;  // master 0 wins the first round-robin tie
      mem_start_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_d_q     <= '0;
      mem_we_q    <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      mem_start_q <= mem_start_d;
      mem_addr_q  <= mem_addr_d;
      mem_d_q     <= mem_d_d;
      mem_we_q    <= mem_we_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign mem_start = mem_start_q;
  assign mem_addr  = mem_addr_q;
  assign mem_d     = mem_d_q;
  assign mem_we    = mem_we_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_q      = m0_rdata_q;
  assign m1_q      = m1_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a behavioural SDRAM controller model, a scoreboard of
// expected transactions, and a second fixed-priority instance for tie-breaking.
module tb_sdram_arbiter;

  logic        clk;
  logic        reset;
  logic        mem_init_done;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [23:0] m0_addr, m1_addr;
  logic [31:0] m0_d, m1_d;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_q, m1_q;
  logic        mem_start, mem_we, mem_busy, mem_q_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_d, mem_q;

  // Fixed-priority instance signals.
  logic        f_m0_req, f_m1_req;
  logic        f_m0_ack, f_m1_ack;
  logic [31:0] f_m0_q, f_m1_q;
  logic        f_mem_start, f_mem_we, f_mem_busy, f_mem_q_ready;
  logic [23:0] f_mem_addr;
  logic [31:0] f_mem_d, f_mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        mst;
    logic        we;
    logic [23:0] addr;
    logic [31:0] d;
  } txn_t;

  txn_t exp_q[$];
  logic [31:0] exp_m0q, exp_m1q;

  typedef enum {C_IDLE, C_REFRESH, C_BUSY, C_DONE} ctrl_e;
  ctrl_e       c_st;
  int          c_cnt;
  int          ctrl_lat;
  int          refresh_want;
  int          refresh_taken;
  logic [23:0] cap_addr;
  logic        cap_we;

  sdram_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_d(m0_d), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_q(m0_q),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_d(m1_d), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_q(m1_q),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we),
    .mem_busy(mem_busy), .mem_q_ready(mem_q_ready), .mem_q(mem_q),
    .mem_init_done(mem_init_done)
  );

  sdram_arbiter #(.FIXED_PRIORITY(1)) dut_fixed (
    .clk(clk), .reset(reset),
    .m0_req(f_m0_req), .m0_addr(m0_addr), .m0_d(m0_d), .m0_we(m0_we),
    .m0_ack(f_m0_ack), .m0_q(f_m0_q),
    .m1_req(f_m1_req), .m1_addr(m1_addr), .m1_d(m1_d), .m1_we(m1_we),
    .m1_ack(f_m1_ack), .m1_q(f_m1_q),
    .mem_start(f_mem_start), .mem_addr(f_mem_addr), .mem_d(f_mem_d), .mem_we(f_mem_we),
    .mem_busy(f_mem_busy), .mem_q_ready(f_mem_q_ready), .mem_q(f_mem_q),
    .mem_init_done(mem_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Read data the controller model returns for an address.
  function automatic logic [31:0] ctrl_data(input logic [23:0] a);
    if (a == 24'h000123) return 32'hDEADBEEF;
    return {8'h5A, a};
  endfunction

  // Controller model plus ack scoreboard; runs just after the falling edge so
  // it sees the stimulus written on that edge.
  always @(negedge clk) begin
    txn_t t;
    #1;
    if (reset) begin
      c_st          = C_IDLE;
      c_cnt         = 0;
      mem_busy      = 1'b0;
      mem_q_ready   = 1'b0;
      f_mem_q_ready = 1'b0;
      exp_q.delete();
      exp_m0q       = '0;
      exp_m1q       = '0;
    end else begin
      f_mem_q_ready = f_mem_start;
      if (f_m0_ack || f_m1_ack) check("fixed_m1_ack", f_m1_ack, 1'b0);

      if (m0_ack || m1_ack) begin
        check("ack_onehot", m0_ack & m1_ack, 1'b0);
        check("ack_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          check("ack_master", m1_ack, t.mst);
          if (!t.we) begin
            if (t.mst) exp_m1q = ctrl_data(t.addr);
            else       exp_m0q = ctrl_data(t.addr);
          end
          check("m0_q", m0_q, exp_m0q);
          check("m1_q", m1_q, exp_m1q);
        end
      end

      case (c_st)
        C_IDLE: begin
          if (mem_start) begin
            if (refresh_want != refresh_taken) begin
              refresh_taken++;
              c_st     = C_REFRESH;
              c_cnt    = 6;
              mem_busy = 1'b1;
            end else begin
              check("start_expected", exp_q.size() != 0, 1'b1);
              if (exp_q.size() != 0) begin
                t = exp_q[0];
                check("mem_addr", mem_addr, t.addr);
                check("mem_we", mem_we, t.we);
                check("mem_d", mem_d, t.d);
              end
              cap_addr = mem_addr;
              cap_we   = mem_we;
              if (ctrl_lat == 0) begin
                mem_q       = cap_we ? 32'h0BAD0BAD : ctrl_data(cap_addr);
                mem_q_ready = 1'b1;
                c_cnt       = 3;
                c_st        = C_DONE;
              end else begin
                mem_busy = 1'b1;
                c_cnt    = ctrl_lat;
                c_st     = C_BUSY;
              end
            end
          end
        end
        C_REFRESH: begin
          check("start_in_refresh", mem_start, 1'b1);
          c_cnt--;
          if (c_cnt == 0) begin
            mem_busy = 1'b0;
            c_st     = C_IDLE;
          end
        end
        C_BUSY: begin
          check("start_held", mem_start, 1'b1);
          c_cnt--;
          if (c_cnt == 0) begin
            mem_busy    = 1'b0;
            mem_q       = cap_we ? 32'h0BAD0BAD : ctrl_data(cap_addr);
            mem_q_ready = 1'b1;
            c_cnt       = 3;
            c_st        = C_DONE;
          end
        end
        C_DONE: begin
          c_cnt--;
          if (c_cnt == 2) check("start_drop", mem_start, 1'b0);
          if (c_cnt == 0) begin
            mem_q_ready = 1'b0;
            c_st        = C_IDLE;
          end
        end
        default: c_st = C_IDLE;
      endcase
    end
  end

  task automatic wait_ack(input logic mst);
    int k = 0;
    while (!(mst ? m1_ack : m0_ack) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ack_timeout", k < 200, 1'b1);
    if (mst) m1_req = 1'b0;
    else     m0_req = 1'b0;
  endtask

  task automatic run_txn(input logic mst, input logic we, input logic [23:0] a,
                         input logic [31:0] d, input int lat);
    txn_t t;
    t.mst = mst; t.we = we; t.addr = a; t.d = d;
    exp_q.push_back(t);
    ctrl_lat = lat;
    if (mst) begin
      m1_addr = a; m1_d = d; m1_we = we; m1_req = 1'b1;
    end else begin
      m0_addr = a; m0_d = d; m0_we = we; m0_req = 1'b1;
    end
    @(negedge clk);
    wait_ack(mst);
  endtask

  initial begin
    txn_t t;
    int   n, fn, k;

    reset = 1'b1; mem_init_done = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_d = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_d = '0;
    f_m0_req = 0; f_m1_req = 0; f_mem_busy = 0; f_mem_q = '0;
    mem_q = '0; ctrl_lat = 1; refresh_want = 0; refresh_taken = 0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_mem_start", mem_start, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 24'h0);
    check("rst_mem_d", mem_d, 32'h0);
    check("rst_m0_ack", m0_ack, 1'b0);
    check("rst_m1_ack", m1_ack, 1'b0);
    check("rst_m0_q", m0_q, 32'h0);
    check("rst_m1_q", m1_q, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Init gating: request held while the controller is still initialising.
    t.mst = 0; t.we = 0; t.addr = 24'h000010; t.d = 32'h10101010;
    exp_q.push_back(t);
    ctrl_lat = 1;
    m0_addr = t.addr; m0_d = t.d; m0_we = 0; m0_req = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("init_gate", mem_start, 1'b0);
    end
    mem_init_done = 1'b1;
    @(negedge clk);
    check("init_grant", mem_start, 1'b1);
    wait_ack(1'b0);

    // Single read from master 0.
    run_txn(1'b0, 1'b0, 24'h000123, 32'h00000000, 2);
    check("read_addr_hold", mem_addr, 24'h000123);

    // Single write from master 1; the latched request holds after the ack.
    run_txn(1'b1, 1'b1, 24'h00FFFF, 32'hCAFEF00D, 3);
    check("write_d_hold", mem_d, 32'hCAFEF00D);
    check("write_we_hold", mem_we, 1'b1);
    repeat (3) @(negedge clk);

    // Contention: both masters on both instances hold req for 4 accesses.
    m0_addr = 24'h000400; m0_d = 32'h00000400; m0_we = 1'b0;
    m1_addr = 24'h000500; m1_d = 32'h00000500; m1_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t.mst = i[0]; t.we = 1'b0;
      t.addr = i[0] ? m1_addr : m0_addr;
      t.d    = i[0] ? m1_d : m0_d;
      exp_q.push_back(t);
    end
    ctrl_lat = 1;
    m0_req = 1'b1; m1_req = 1'b1; f_m0_req = 1'b1; f_m1_req = 1'b1;
    n = 0; fn = 0; k = 0;
    while ((n < 4 || fn < 4) && k < 400) begin
      @(negedge clk);
      k++;
      if (m0_ack || m1_ack) begin
        n++;
        if (n == 4) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
      if (f_m0_ack || f_m1_ack) begin
        fn++;
        if (fn == 4) begin f_m0_req = 1'b0; f_m1_req = 1'b0; end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; f_m0_req = 1'b0; f_m1_req = 1'b0;
    check("rr_ack_count", n, 4);
    check("fixed_ack_count", fn, 4);
    check("fixed_addr", f_mem_addr, 24'h000400);
    repeat (3) @(negedge clk);

    // Write from master 1 after it has read data: its q must not change.
    run_txn(1'b1, 1'b1, 24'h000777, 32'h12345678, 0);
    repeat (2) @(negedge clk);

    // Refresh pre-empts the access as mem_start rises.
    refresh_want++;
    run_txn(1'b0, 1'b0, 24'h000200, 32'h0, 2);
    check("refresh_taken", refresh_taken, refresh_want);
    repeat (6) @(negedge clk);
    check("refresh_single_ack", exp_q.size(), 0);

    // Reset in DRAIN: nothing completes, q registers clear.
    t.mst = 0; t.we = 0; t.addr = 24'h000300; t.d = 32'h0;
    exp_q.push_back(t);
    ctrl_lat = 3;
    m0_addr = t.addr; m0_d = t.d; m0_we = 0; m0_req = 1'b1;
    k = 0;
    while (!(mem_q_ready && !mem_start) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_reached", k < 100, 1'b1);
    reset = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rmid_mem_start", mem_start, 1'b0);
    check("rmid_m0_ack", m0_ack, 1'b0);
    check("rmid_m1_ack", m1_ack, 1'b0);
    check("rmid_m0_q", m0_q, 32'h0);
    check("rmid_m1_q", m1_q, 32'h0);
    repeat (8) begin
      @(negedge clk);
      check("rmid_no_ack", m0_ack | m1_ack, 1'b0);
    end

    // Normal read after the reset.
    run_txn(1'b0, 1'b0, 24'h000123, 32'h0, 1);
    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
